uart_packet_framer: RTL and testbench

//  Transmit-side framer that builds checksum|addr|count|payload packets for the UART Rs232Tx byte sender.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_frame_buf.sv | 24 ++
 rtl/uart_packet_framer.sv | 130 +++++++++++++
 tb/tb_uart_packet_framer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART packet framer.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, CK, ADDR, CNT, DATA} state_t;
    typedef enum logic [1:0] {ISSUE, WAIT_HI, WAIT_LO} phase_t;

    localparam int PKT_HDR_BYTES = 3;

    // Checksum byte that makes the mod-256 sum of the whole packet zero.
    function automatic logic [7:0] calc_ck(input logic [7:0] sum,
                                           input logic [7:0] addr,
                                           input logic [7:0] cnt);
        logic [7:0] t;
        t = sum + addr + cnt;
        return ~t + 8'd1;
    endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// DEPTHx8 single-port payload RAM: synchronous write, registered read.
module uart_frame_buf #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    // One shared address; read data holds when re is low.
    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        if (re)
            rdata <= mem[addr];
    end

endmodule

// File: rtl/uart_packet_framer.sv
// Builds checksum|addr|count|payload packets and hands them byte by byte
// to an Rs232Tx-style sender over the send/sending handshake.
module uart_packet_framer
    import uart_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic       clk,
    input  logic       RESET_N,
    input  logic [7:0] pkt_addr,
    input  logic [7:0] wr_data,
    input  logic       wr_en,
    input  logic       commit,
    output logic       busy,
    output logic       wr_drop,
    output logic [7:0] tx_data,
    output logic       tx_send,
    input  logic       tx_sending
);

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [AW:0] fill_q, fill_n, rd_ptr_q;
    logic [7:0]  sum_q, sum_n, addr_q, cnt_q, ck_q, rd_data;
    logic        wr_ok, commit_ok, byte_done, last, pkt_end;
    logic        ram_re;
    logic [AW-1:0] ram_addr;

    // Write acceptance and the fill/sum values a same-cycle commit must see.
    always_comb begin
        wr_ok     = wr_en && (state_q == IDLE) && (fill_q != (AW+1)'(DEPTH));
        fill_n    = fill_q + (AW+1)'(wr_ok);
        sum_n     = wr_ok ? sum_q + wr_data : sum_q;
        commit_ok = commit && (state_q == IDLE) && (fill_n != '0);
        tx_send   = (state_q != IDLE) && (phase_q == ISSUE) && !tx_sending;
        byte_done = (state_q != IDLE) && (phase_q == WAIT_LO) && !tx_sending;
        last      = (rd_ptr_q == fill_q);
        pkt_end   = (state_q == DATA) && byte_done && last;
        busy      = (state_q != IDLE);
    end

    // Byte presented to the sender: header registers, then RAM read data.
    always_comb begin
        tx_data = 8'h00;
        case (state_q)
            CK:      tx_data = ck_q;
            ADDR:    tx_data = addr_q;
            CNT:     tx_data = cnt_q;
            DATA:    tx_data = rd_data;
            default: tx_data = 8'h00;
        endcase
    end

    // Next byte state and handshake phase.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (state_q != IDLE) begin
            case (phase_q)
                ISSUE:   if (tx_send)     phase_d = WAIT_HI;
                WAIT_HI: if (tx_sending)  phase_d = WAIT_LO;
                WAIT_LO: if (!tx_sending) phase_d = ISSUE;
                default: phase_d = ISSUE;
            endcase
        end
        case (state_q)
            IDLE:    if (commit_ok) state_d = CK;
            CK:      if (byte_done) state_d = ADDR;
            ADDR:    if (byte_done) state_d = CNT;
            CNT:     if (byte_done) state_d = DATA;
            DATA:    if (pkt_end)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, counters, header latch and sticky drop flag.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= IDLE;
            phase_q  <= ISSUE;
            fill_q   <= '0;
            sum_q    <= '0;
            rd_ptr_q <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            ck_q     <= '0;
            wr_drop  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            if (wr_en && !wr_ok)
                wr_drop <= 1'b1;
            if (pkt_end) begin
                fill_q   <= '0;
                sum_q    <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (wr_ok) begin
                    fill_q <= fill_n;
                    sum_q  <= sum_n;
                end
                if ((state_q == DATA) && tx_send)
                    rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (commit_ok) begin
                addr_q <= pkt_addr;
                cnt_q  <= 8'(fill_n);
                ck_q   <= calc_ck(sum_n, pkt_addr, 8'(fill_n));
            end
        end
    end

    // Writes use the fill pointer; reads prefetch the next byte while the
    // previous one drains (WAIT_LO), so data is ready at ISSUE.
    always_comb begin
        ram_addr = (state_q == IDLE) ? fill_q[AW-1:0] : rd_ptr_q[AW-1:0];
        ram_re   = (state_q != IDLE) && (phase_q == WAIT_LO);
    end

    uart_frame_buf #(.DEPTH(DEPTH), .AW(AW)) u_buf (
        .clk   (clk),
        .we    (wr_ok),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (wr_data),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_packet_framer.sv
// Directed bench for uart_packet_framer with a simple Rs232Tx responder.
module tb_uart_packet_framer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       RESET_N;
    logic [7:0] pkt_addr, wr_data;
    logic       wr_en, commit;
    logic       busy, wr_drop, tx_send;
    logic [7:0] tx_data;
    logic       tx_sending;

    int n_tot = 0;
    int n_bad = 0;
    logic [7:0] cap_q[$];
    logic [7:0] pay_q[$];

    uart_packet_framer #(.DEPTH(256), .AW(8)) dut (
        .clk        (clk),
        .RESET_N    (RESET_N),
        .pkt_addr   (pkt_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .commit     (commit),
        .busy       (busy),
        .wr_drop    (wr_drop),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_sending (tx_sending)
    );

    always #5 clk = ~clk;

    // Sender model: latch byte on send, raise sending, drop it two cycles later.
    initial tx_sending = 1'b0;
    always begin
        @(negedge clk);
        if (tx_send === 1'b1) begin
            cap_q.push_back(tx_data);
            @(negedge clk);
            tx_sending = 1'b1;
            repeat (2) @(negedge clk);
            tx_sending = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tot++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic [7:0] d, input logic c, input logic [7:0] a);
        @(negedge clk);
        wr_en = 1'b1; wr_data = d; commit = c; pkt_addr = a;
        @(negedge clk);
        wr_en = 1'b0; commit = 1'b0;
    endtask

    task automatic cmt(input logic [7:0] a);
        @(negedge clk);
        pkt_addr = a; commit = 1'b1;
        @(negedge clk);
        commit = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int c = 0;
        while (busy === 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk("done_timeout", busy, 1'b0);
    endtask

    task automatic wait_quiet();
        int c = 0;
        while (tx_sending === 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        chk("sender_quiet", tx_sending, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        RESET_N = 1'b0;
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        wait_quiet();
        cap_q.delete();
    endtask

    task automatic chk_bytes(input string tag, input logic [7:0] exp[$]);
        chk({tag, "_len"}, cap_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < cap_q.size(); i++)
            chk(tag, cap_q[i], exp[i]);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] a, s;
        int len, c;

        RESET_N = 1'b0; wr_en = 1'b0; commit = 1'b0; wr_data = 8'h00; pkt_addr = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", wr_drop, 1'b0);
        chk("rst_send", tx_send, 1'b0);
        chk("rst_data", tx_data, 8'h00);
        RESET_N = 1'b1;

        // Commit with an empty buffer does nothing.
        cmt(8'h55);
        chk("empty_busy", busy, 1'b0);
        repeat (10) @(negedge clk);
        chk("empty_nobytes", cap_q.size(), 0);

        // 1: three-byte packet, checksum E5, one-cycle latency.
        put(8'h01, 1'b0, 8'h12); put(8'h02, 1'b0, 8'h12); put(8'h03, 1'b0, 8'h12);
        cmt(8'h12);
        chk("t1_busy", busy, 1'b1);
        chk("t1_send_lat", tx_send, 1'b1);
        chk("t1_ck_out", tx_data, 8'hE5);
        wait_done(400);
        chk("t1_sending_low", tx_sending, 1'b0);
        exp_q = '{8'hE5, 8'h12, 8'h03, 8'h01, 8'h02, 8'h03};
        chk_bytes("t1", exp_q);
        cap_q.delete();

        // 2: full 256-byte zero packet, count encodes as 0x00.
        for (int i = 0; i < 256; i++) put(8'h00, 1'b0, 8'h00);
        chk("t2_nodrop", wr_drop, 1'b0);
        cmt(8'h00);
        wait_done(4000);
        exp_q.delete();
        for (int i = 0; i < 256 + PKT_HDR_BYTES; i++) exp_q.push_back(8'h00);
        chk_bytes("t2", exp_q);
        cap_q.delete();

        // 3: 257th write is dropped; payload 0..255 sums to 0x80 -> ck 0x80.
        for (int i = 0; i < 256; i++) put(8'(i), 1'b0, 8'h00);
        put(8'hAA, 1'b0, 8'h00);
        chk("t3_drop", wr_drop, 1'b1);
        cmt(8'h00);
        wait_done(4000);
        exp_q = '{8'h80, 8'h00, 8'h00};
        for (int i = 0; i < 256; i++) exp_q.push_back(8'(i));
        chk_bytes("t3", exp_q);
        do_reset();
        chk("t3_drop_clr", wr_drop, 1'b0);

        // 4: writes and commit while busy are rejected/ignored.
        put(8'h10, 1'b0, 8'h30); put(8'h20, 1'b0, 8'h30);
        cmt(8'h30);
        put(8'h99, 1'b1, 8'h77);
        chk("t4_drop", wr_drop, 1'b1);
        wait_done(400);
        repeat (40) @(negedge clk);
        chk("t4_idle", busy, 1'b0);
        exp_q = '{8'h9E, 8'h30, 8'h02, 8'h10, 8'h20};
        chk_bytes("t4", exp_q);
        do_reset();

        // 5: reset while payload byte 2 is in flight, then a clean 1-byte packet.
        for (int i = 1; i <= 4; i++) put(8'(i), 1'b0, 8'h40);
        cmt(8'h40);
        c = 0;
        while (cap_q.size() < 5 && c < 200) begin @(negedge clk); c++; end
        chk("t5_reach", cap_q.size(), 5);
        RESET_N = 1'b0;
        #1;
        chk("t5_send", tx_send, 1'b0);
        chk("t5_busy", busy, 1'b0);
        @(negedge clk);
        RESET_N = 1'b1;
        wait_quiet();
        cap_q.delete();
        put(8'h07, 1'b0, 8'h05);
        cmt(8'h05);
        wait_done(400);
        exp_q = '{8'hF3, 8'h05, 8'h01, 8'h07};
        chk_bytes("t5", exp_q);
        cap_q.delete();

        // 6: random packets; last byte written in the same cycle as commit.
        for (int p = 0; p < 50; p++) begin
            a   = 8'($urandom_range(0, 255));
            len = $urandom_range(1, 64);
            pay_q.delete();
            for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom_range(0, 255)));
            for (int i = 0; i < len; i++) put(pay_q[i], (i == len - 1), a);
            wait_done(2000);
            chk("t6_len", cap_q.size(), len + PKT_HDR_BYTES);
            if (cap_q.size() == len + PKT_HDR_BYTES) begin
                s = 8'h00;
                foreach (cap_q[i]) s = s + cap_q[i];
                chk("t6_sum0", s, 8'h00);
                chk("t6_addr", cap_q[1], a);
                chk("t6_cnt", cap_q[2], 8'(len));
                for (int i = 0; i < len; i++) chk("t6_pay", cap_q[i + 3], pay_q[i]);
            end
            cap_q.delete();
        end
        chk("t6_nodrop", wr_drop, 1'b0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
